// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, redirect flushes, MDU stalls, stall watchdog.
// Optional event counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int STALL_TIMEOUT    = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_is_load_i,
    input  logic        ex_redirect_i,
    input  logic        ex_mdu_start_i,
    input  logic        mdu_done_i,
    output logic        pc_stall_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        exmem_flush_o,
    output logic        ex_sel_mdu_o,
    output logic        stall_timeout_o,
    output logic [31:0] perf_loaduse_o,
    output logic [31:0] perf_redirect_o,
    output logic [31:0] perf_stall_o
);

    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, FLUSH, MDU_WAIT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic [SW-1:0] scnt_q;
    logic          timeout_q;

    logic redirect, load_use, mdu_start;
    logic pc_stall, ifid_stall, ifid_flush;
    logic idex_flush, exmem_flush, sel_mdu;

    assign redirect  = ex_redirect_i & ex_valid_i;
    assign mdu_start = ex_mdu_start_i & ex_valid_i;
    assign load_use  = id_valid_i & ex_valid_i & ex_is_load_i
                     & (ex_rd_i != 5'd0)
                     & ((id_uses_rs1_i & (id_rs1_i == ex_rd_i))
                      | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        sel_mdu     = 1'b0;
        unique case (state_q)
            MDU_WAIT: begin
                pc_stall    = ~mdu_done_i;
                ifid_stall  = ~mdu_done_i;
                idex_flush  = ~mdu_done_i;
                exmem_flush = ~mdu_done_i;
                if (mdu_done_i) begin
                    sel_mdu = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                if (state_q == FLUSH) begin
                    ifid_flush = 1'b1;
                    fcnt_d     = fcnt_q - 4'd1;
                    if (fcnt_q <= 4'd1) state_d = RUN;
                end
                if (redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (REDIRECT_BUBBLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = 4'(REDIRECT_BUBBLES - 1);
                    end
                end else if (mdu_start) begin
                    if (mdu_done_i) begin
                        sel_mdu = 1'b1;
                    end else begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        state_d     = MDU_WAIT;
                        fcnt_d      = 4'd0;
                    end
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Saturating run-length of PC stalls; the error flag is sticky.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scnt_q    <= '0;
            timeout_q <= 1'b0;
        end else if (pc_stall) begin
            if (scnt_q != SW'(STALL_TIMEOUT)) scnt_q <= scnt_q + 1'b1;
            if (scnt_q >= SW'(STALL_TIMEOUT - 1)) timeout_q <= 1'b1;
        end else begin
            scnt_q <= '0;
        end
    end

    assign pc_stall_o      = rst_ni & pc_stall;
    assign ifid_stall_o    = rst_ni & ifid_stall;
    assign ifid_flush_o    = rst_ni & ifid_flush;
    assign idex_flush_o    = rst_ni & idex_flush;
    assign exmem_flush_o   = rst_ni & exmem_flush;
    assign ex_sel_mdu_o    = rst_ni & sel_mdu;
    assign stall_timeout_o = timeout_q;

`ifdef HAZARD_PERF_EN
    logic        lu_take, redir_take;
    logic [31:0] cnt_lu, cnt_redir, cnt_stall;

    assign redir_take = (state_q != MDU_WAIT) & redirect;
    assign lu_take    = (state_q != MDU_WAIT) & ~redirect
                      & ~mdu_start & load_use;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_lu    <= '0;
            cnt_redir <= '0;
            cnt_stall <= '0;
        end else begin
            if (lu_take)    cnt_lu    <= cnt_lu + 32'd1;
            if (redir_take) cnt_redir <= cnt_redir + 32'd1;
            if (pc_stall)   cnt_stall <= cnt_stall + 32'd1;
        end
    end

    assign perf_loaduse_o  = cnt_lu;
    assign perf_redirect_o = cnt_redir;
    assign perf_stall_o    = cnt_stall;
`else
    assign perf_loaduse_o  = 32'd0;
    assign perf_redirect_o = 32'd0;
    assign perf_stall_o    = 32'd0;
`endif

endmodule
